// File: rtl/uart_echo_responder_if.sv
// uart_echo_responder_if
//   Bundles the receive/transmit handshake and the status outputs of the echo
//   responder.
//   slave modport  (the responder): takes data_rx, ready_rx, ready_tx;
//                                   drives data_tx, start_tx, count, overflow, busy.
//   master modport (uart/host side): the mirror image.
//   DEPTH must match the responder's DEPTH because it sets the width of count.
interface uart_echo_responder_if #(
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [7:0]    data_rx;
    logic          ready_rx;
    logic          ready_tx;
    logic [7:0]    data_tx;
    logic          start_tx;
    logic [CW-1:0] count;
    logic          overflow;
    logic          busy;

    modport slave (
        input  data_rx,
        input  ready_rx,
        input  ready_tx,
        output data_tx,
        output start_tx,
        output count,
        output overflow,
        output busy
    );

    modport master (
        output data_rx,
        output ready_rx,
        output ready_tx,
        input  data_tx,
        input  start_tx,
        input  count,
        input  overflow,
        input  busy
    );
endinterface

// File: rtl/uart_echo_responder.sv
// uart_echo_responder
//   Echoes every byte received from a uart back to its transmitter through a
//   DEPTH-byte FIFO. Bytes arriving while the FIFO is full (and not being
//   popped in the same cycle) are dropped and latch the sticky overflow flag.
//   A three-state transmit FSM launches one byte each time the transmitter
//   reports idle, then waits for it to go busy and come back idle.
//
//   Ports:
//     clk  - sole clock, rising edge
//     rst  - asynchronous active-high reset
//     bus  - uart_echo_responder_if.slave:
//              data_rx/ready_rx : received byte and its one-cycle strobe
//              ready_tx         : transmitter idle
//              data_tx/start_tx : registered byte and one-cycle launch pulse
//              count            : bytes held in the FIFO
//              overflow         : sticky "byte dropped" flag
//              busy             : FSM not idle or FIFO non-empty
//
//   Parameter DEPTH: FIFO depth in bytes, power of two in 2..64.
//   Optional macro UART_ECHO_UPCASE_EN: when defined, lowercase ASCII
//   ('a'..'z') is stored as uppercase; otherwise bytes are stored unchanged.
module uart_echo_responder #(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    uart_echo_responder_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t        state_reg;
    logic [7:0]    data_tx_reg;
    logic          start_tx_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          overflow_reg;

    logic [7:0]    mem [DEPTH];

    logic [7:0]    rx_byte;
    logic          fifo_full;
    logic          pop;
    logic          push_ok;

    function automatic logic [7:0] store_byte(input logic [7:0] b);
`ifdef UART_ECHO_UPCASE_EN
        if (b >= 8'h61 && b <= 8'h7A) begin
            return b - 8'h20;
        end
        return b;
`else
        return b;
`endif
    endfunction

    assign rx_byte   = store_byte(bus.data_rx);
    assign fifo_full = (count_reg == CW'(DEPTH));

    // The launch decision is made from current state, so a full FIFO that is
    // being popped this cycle still has room for an incoming byte.
    assign pop     = (state_reg == IDLE) && (count_reg != '0) && bus.ready_tx;
    assign push_ok = bus.ready_rx && (!fifo_full || pop);

    // Storage array: written only, no reset, so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= rx_byte;
        end
    end

    // FIFO bookkeeping and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            if (push_ok && !pop) begin
                count_reg <= count_reg + CW'(1);
            end else if (pop && !push_ok) begin
                count_reg <= count_reg - CW'(1);
            end
            if (bus.ready_rx && !push_ok) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // Transmit FSM with registered launch outputs. data_tx_reg doubles as the
    // registered read port of the storage array and holds between launches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            data_tx_reg  <= 8'h00;
            start_tx_reg <= 1'b0;
        end else begin
            start_tx_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (pop) begin
                        data_tx_reg  <= mem[rd_ptr_reg];
                        start_tx_reg <= 1'b1;
                        state_reg    <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    if (!bus.ready_tx) begin
                        state_reg <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    // Return to IDLE only; the next launch is evaluated from
                    // IDLE on the following cycle.
                    if (bus.ready_tx) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.data_tx  = data_tx_reg;
    assign bus.start_tx = start_tx_reg;
    assign bus.count    = count_reg;
    assign bus.overflow = overflow_reg;
    assign bus.busy     = (state_reg != IDLE) || (count_reg != '0);

endmodule

// File: tb/tb_uart_echo_responder.sv
module tb_uart_echo_responder;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

`ifdef UART_ECHO_UPCASE_EN
    localparam logic [7:0] EXP61 = 8'h41;
`else
    localparam logic [7:0] EXP61 = 8'h61;
`endif

    logic clk;
    logic rst;

    uart_echo_responder_if #(.DEPTH(DEPTH)) bus ();

    uart_echo_responder #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic          rx;
        logic [7:0]    din;
        logic          tx;
        logic          exp_start;
        logic [7:0]    exp_data;
        logic [CW-1:0] exp_count;
        logic          exp_busy;
    } vec_t;

    vec_t vecs[12];
    logic [7:0] got[$];
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        bus.ready_rx = 1'b1;
        bus.data_rx  = b;
        tick();
        bus.ready_rx = 1'b0;
        bus.data_rx  = 8'h00;
    endtask

    // Emulated transmitter: after each start_tx it holds ready_tx low for 10
    // cycles, then raises it. Collects launched bytes until the DUT goes idle.
    task automatic drain(input int n, input int budget);
        int  low;
        bit  done;
        low  = 0;
        done = 1'b0;
        got.delete();
        for (int cyc = 0; cyc < budget; cyc++) begin
            if (bus.start_tx) begin
                got.push_back(bus.data_tx);
                low = 10;
            end
            if (got.size() >= n && low == 0 && !bus.busy) begin
                done = 1'b1;
                break;
            end
            if (low > 0) begin
                bus.ready_tx = 1'b0;
                low--;
            end else begin
                bus.ready_tx = 1'b1;
            end
            tick();
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d bytes, expected %0d then idle", got.size(), n);
        end
    endtask

    task automatic cmp_drain(input string name);
        chk({name, "_len"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got.size()) begin
                $display("%s byte %0d: data_tx=%02h expected %02h", name, i, got[i], exp_q[i]);
                chk($sformatf("%s_byte%0d", name, i), got[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        int starts;

        vecs[0]  = '{1'b1, 8'h41, 1'b1, 1'b0, 8'h00,  4'd1, 1'b1};
        vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h41,  4'd0, 1'b1};
        vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h41,  4'd0, 1'b1};
        vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h41,  4'd0, 1'b1};
        vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h41,  4'd0, 1'b0};
        vecs[5]  = '{1'b1, 8'h61, 1'b1, 1'b0, 8'h41,  4'd1, 1'b1};
        vecs[6]  = '{1'b1, 8'h5A, 1'b1, 1'b1, EXP61,  4'd1, 1'b1};
        vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, EXP61,  4'd1, 1'b1};
        vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, EXP61,  4'd1, 1'b1};
        vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h5A,  4'd0, 1'b1};
        vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h5A,  4'd0, 1'b1};
        vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h5A,  4'd0, 1'b0};

        // Reset held with ready_tx high: outputs must stay at reset values.
        rst          = 1'b1;
        bus.data_rx  = 8'h00;
        bus.ready_rx = 1'b0;
        bus.ready_tx = 1'b1;
        repeat (3) tick();
        chk("rst_start_tx", bus.start_tx, 0);
        chk("rst_data_tx",  bus.data_tx,  8'h00);
        chk("rst_count",    bus.count,    0);
        chk("rst_overflow", bus.overflow, 0);
        chk("rst_busy",     bus.busy,     0);
        rst = 1'b0;

        // Table: first vector pushes in the first cycle after release.
        for (int i = 0; i < 12; i++) begin
            bus.ready_rx = vecs[i].rx;
            bus.data_rx  = vecs[i].din;
            bus.ready_tx = vecs[i].tx;
            tick();
            $display("vec %0d: rx=%0b din=%02h tx=%0b -> start=%0b data=%02h count=%0d busy=%0b",
                     i, vecs[i].rx, vecs[i].din, vecs[i].tx,
                     bus.start_tx, bus.data_tx, bus.count, bus.busy);
            chk($sformatf("v%0d_start", i), bus.start_tx, vecs[i].exp_start);
            chk($sformatf("v%0d_data", i),  bus.data_tx,  vecs[i].exp_data);
            chk($sformatf("v%0d_count", i), bus.count,    vecs[i].exp_count);
            chk($sformatf("v%0d_busy", i),  bus.busy,     vecs[i].exp_busy);
            chk($sformatf("v%0d_ovf", i),   bus.overflow, 0);
        end
        bus.ready_rx = 1'b0;

        // Burst of 8 with transmitter busy, then full-plus-pop with 8'hAA.
        bus.ready_tx = 1'b0;
        starts = 0;
        for (int i = 0; i < 8; i++) begin
            push_byte(8'(i));
            if (bus.start_tx) starts++;
        end
        $display("burst: count=%0d overflow=%0b starts=%0d", bus.count, bus.overflow, starts);
        chk("burst_count", bus.count, 8);
        chk("burst_no_start", starts, 0);
        chk("burst_ovf", bus.overflow, 0);
        bus.ready_tx = 1'b1;
        push_byte(8'hAA);
        $display("full+pop: start=%0b data=%02h count=%0d overflow=%0b",
                 bus.start_tx, bus.data_tx, bus.count, bus.overflow);
        chk("fullpop_start", bus.start_tx, 1);
        chk("fullpop_data",  bus.data_tx,  8'h00);
        chk("fullpop_count", bus.count,    8);
        chk("fullpop_ovf",   bus.overflow, 0);
        drain(9, 400);
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(8'(i));
        exp_q.push_back(8'hAA);
        cmp_drain("burst");
        chk("burst_end_count", bus.count, 0);

        // Overflow: 9 pushes into an 8-deep FIFO with transmitter busy.
        bus.ready_tx = 1'b0;
        starts = 0;
        for (int i = 0; i < 9; i++) begin
            push_byte(8'h10 + 8'(i));
            if (bus.start_tx) starts++;
        end
        $display("overflow: count=%0d overflow=%0b starts=%0d", bus.count, bus.overflow, starts);
        chk("ovf_count", bus.count, 8);
        chk("ovf_flag", bus.overflow, 1);
        chk("ovf_no_start", starts, 0);
        drain(8, 400);
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(8'h10 + 8'(i));
        cmp_drain("ovf");
        chk("ovf_sticky", bus.overflow, 1);

        // Reset mid-transmission: count=3, FSM in WAIT_BUSY.
        bus.ready_tx = 1'b0;
        for (int i = 0; i < 4; i++) push_byte(8'h20 + 8'(i));
        bus.ready_tx = 1'b1;
        tick();
        $display("pre-reset: start=%0b data=%02h count=%0d", bus.start_tx, bus.data_tx, bus.count);
        chk("mid_start", bus.start_tx, 1);
        chk("mid_count", bus.count, 3);
        #3 rst = 1'b1;
        #1;
        $display("async reset: start=%0b data=%02h count=%0d ovf=%0b busy=%0b",
                 bus.start_tx, bus.data_tx, bus.count, bus.overflow, bus.busy);
        chk("arst_start_tx", bus.start_tx, 0);
        chk("arst_data_tx",  bus.data_tx,  8'h00);
        chk("arst_count",    bus.count,    0);
        chk("arst_overflow", bus.overflow, 0);
        chk("arst_busy",     bus.busy,     0);
        tick();
        rst = 1'b0;
        starts = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.start_tx) starts++;
        end
        $display("post-reset idle: starts=%0d busy=%0b", starts, bus.busy);
        chk("post_rst_no_start", starts, 0);
        chk("post_rst_busy", bus.busy, 0);
        push_byte(8'h33);
        chk("post_rst_lat1", bus.start_tx, 0);
        tick();
        $display("post-reset echo: start=%0b data=%02h", bus.start_tx, bus.data_tx);
        chk("post_rst_start", bus.start_tx, 1);
        chk("post_rst_data",  bus.data_tx,  8'h33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_echo_responder.md
UART_ECHO_RESPONDER -- requirements
Module: uart_echo_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning receive-to-transmit FIFO depth in bytes; it SHALL be a power of two, 2..64.
REQ-002 The block SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have port data_rx  input  8  received byte from uart; valid only while ready_rx=1.
REQ-005 The block SHALL have port ready_rx  input  1  one-cycle pulse marking a new data_rx byte.
REQ-006 The block SHALL have port ready_tx  input  1  high while the uart transmitter is idle and can accept start_tx.
REQ-007 The block SHALL have port data_tx  output  8  byte to transmit; registered.
REQ-008 The block SHALL have port start_tx  output  1  one-cycle launch pulse to the uart transmitter; registered.
REQ-009 The block SHALL have port count  output  $clog2(DEPTH)+1  bytes currently held in the FIFO.
REQ-010 The block SHALL have port overflow  output  1  sticky flag: a received byte was dropped.
REQ-011 The block SHALL have port busy  output  1  high when FSM is not IDLE or count is nonzero.

Function
REQ-012 On each cycle with ready_rx=1 the block SHALL push data_rx (after optional transform, REQ-027) into the FIFO tail.
REQ-013 A push SHALL be accepted when count<DEPTH, or when count=DEPTH and a pop occurs in the same cycle; otherwise the byte SHALL be dropped and overflow set to 1.
REQ-014 Simultaneous push and pop SHALL leave count unchanged; pop on empty SHALL never occur.
REQ-015 FIFO pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH nor go below 0.
REQ-016 The transmit FSM SHALL have states IDLE, WAIT_BUSY, WAIT_DONE.
REQ-017 In IDLE, when count>0 and ready_tx=1, the block SHALL load data_tx with the FIFO head, assert start_tx for exactly one cycle, pop the head, and enter WAIT_BUSY.
REQ-018 In WAIT_BUSY the block SHALL stay until ready_tx=0, then enter WAIT_DONE.
REQ-019 In WAIT_DONE the block SHALL stay until ready_tx=1, then enter IDLE; no launch SHALL occur in the same cycle as this transition.
REQ-020 data_tx SHALL hold its last launched value until the next launch.
REQ-021 Latency: a byte pushed into an empty FIFO with FSM in IDLE and ready_tx=1 SHALL produce start_tx=1 exactly 2 cycles after its ready_rx cycle.
REQ-022 Byte order on data_tx SHALL equal arrival order of accepted bytes.
REQ-023 overflow SHALL remain 1 once set until reset.

Reset
REQ-024 While rst=1, regardless of clk, the block SHALL force FSM=IDLE, count=0, FIFO pointers=0, data_tx=8'h00, start_tx=0, overflow=0, busy=0.
REQ-025 Reset asserted mid-transmission SHALL discard all FIFO contents and the in-flight launch state; after release the block SHALL wait in IDLE for new data.
REQ-026 A ready_rx pulse in the first cycle after reset release SHALL be accepted normally.

Configuration
REQ-027 With macro UART_ECHO_UPCASE_EN defined, bytes 8'h61..8'h7A SHALL be stored minus 8'h20 and all other bytes unchanged; without it all bytes SHALL be stored unchanged.

Verification
REQ-028 Single byte: ready_tx=1, pulse ready_rx with 8'h41 -> start_tx=1 two cycles later, data_tx=8'h41, count returns to 0.
REQ-029 Burst: ready_tx=0, push 8 bytes 8'h00..8'h07 -> count=8, no start_tx; then emulate transmitter (ready_tx low 10 cycles after each start) -> data_tx sequence 8'h00..8'h07, count=0.
REQ-030 Overflow: with ready_tx=0 push 9 bytes -> count=8, overflow=1, 9th byte never transmitted; overflow stays 1 until rst.
REQ-031 Full plus pop: count=8, FSM IDLE, ready_tx rises in the same cycle as ready_rx with 8'hAA -> launch occurs, 8'hAA accepted, count stays 8, overflow=0.
REQ-032 Transform: push 8'h61 and 8'h5A -> data_tx 8'h41, 8'h5A with UART_ECHO_UPCASE_EN; 8'h61, 8'h5A without.
REQ-033 Reset mid-operation: count=3, FSM in WAIT_BUSY, assert rst between clock edges -> all outputs at reset values immediately; after release no start_tx until a new ready_rx.
